// File: rtl/array_op_scheduler.sv
// Two-requester round-robin scheduler for a shared 4x32 result array.
// Each accepted command spends EXEC_LAT cycles in EXEC. It then spends one
// cycle in WRITE, where the result is committed and done pulses.
module array_op_scheduler #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int AW       = 2,
    parameter int EXEC_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [AW-1:0]    done_addr,
    output logic [7:0]       op_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;
    localparam int CW = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [1:0]       op_q, op_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             id_q, id_d;
    logic [CW-1:0]    exec_cnt_q, exec_cnt_d;
    logic [WIDTH-1:0] array_q [DEPTH];
    logic [WIDTH-1:0] array_d [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic [AW-1:0]    done_addr_q, done_addr_d;
    logic [7:0]       op_cnt_q, op_cnt_d;
    logic             grant0, grant1;
    logic [WIDTH-1:0] result;

    // Round-robin grant: on a tie, the side that did not win last time wins.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant_q);
        grant1     = req1_valid & ~grant0;
        req0_ready = (state_q == IDLE) & grant0;
        req1_ready = (state_q == IDLE) & grant1;
    end

    // The arithmetic unit only sees captured operands, never live inputs.
    always_comb begin
        unique case (op_q)
            2'b00:   result = data_q >> 1;
            2'b01:   result = data_q % WIDTH'(5);
            2'b10:   result = data_q * data_q;
            default: result = data_q >> 2;
        endcase
    end

    // Next-state logic: command capture, EXEC countdown, array commit.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        addr_d       = addr_q;
        data_d       = data_q;
        id_d         = id_q;
        exec_cnt_d   = exec_cnt_q;
        array_d      = array_q;
        done_d       = 1'b0;
        done_id_d    = done_id_q;
        done_addr_d  = done_addr_q;
        op_cnt_d     = op_cnt_q;
        rd_data_d    = array_q[rd_addr];
        unique case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    op_d         = grant1 ? req1_op   : req0_op;
                    addr_d       = grant1 ? req1_addr : req0_addr;
                    data_d       = grant1 ? req1_data : req0_data;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    exec_cnt_d   = CW'(EXEC_LAT - 1);
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (exec_cnt_q == '0) begin
                    state_d     = WRITE;
                    done_d      = 1'b1;
                    done_id_d   = id_q;
                    done_addr_d = addr_q;
                end else begin
                    exec_cnt_d = exec_cnt_q - CW'(1);
                end
            end
            WRITE: begin
                array_d[addr_q] = result;
                if (op_cnt_q != 8'hFF) op_cnt_d = op_cnt_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; asynchronous reset aborts any in-flight command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            id_q         <= 1'b0;
            exec_cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) array_q[i] <= '0;
            rd_data_q    <= '0;
            done_q       <= 1'b0;
            done_id_q    <= 1'b0;
            done_addr_q  <= '0;
            op_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            id_q         <= id_d;
            exec_cnt_q   <= exec_cnt_d;
            array_q      <= array_d;
            rd_data_q    <= rd_data_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            done_addr_q  <= done_addr_d;
            op_cnt_q     <= op_cnt_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign done_addr = done_addr_q;
    assign op_cnt    = op_cnt_q;
endmodule
